// File: rtl/halli_galli_pkg.sv
// Shared constants and types for the Halli Galli referee.
// Holds FSM state codes, width helpers and the card record.
package halli_galli_pkg;

    typedef logic [2:0] hg_state_t;

    localparam hg_state_t ST_PLAY  = 3'd0;
    localparam hg_state_t ST_JUDGE = 3'd1;
    localparam hg_state_t ST_COOL  = 3'd2;
    localparam hg_state_t ST_FINAL = 3'd3;
    localparam hg_state_t ST_OVER  = 3'd4;

    // Card record at the default field widths.
    typedef struct packed {
        logic [1:0] color;
        logic [2:0] number;
    } card_t;

    // Index width for n items, never below one bit.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/halli_galli_referee_bell_arbiter.sv
// Bell edge detection and grant selection for the referee.
// Ports: clk, rst, clr (sync clear), bell[N] levels, upd/last (pointer
// update from the judge, used with RR_ARB_EN), any_rise, grant index.
// RR_ARB_EN selects round-robin priority; otherwise lowest index wins.
module bell_arbiter
    import halli_galli_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = width_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [N-1:0]  bell,
    input  logic          upd,
    input  logic [PW-1:0] last,
    output logic          any_rise,
    output logic [PW-1:0] grant
);

    logic [N-1:0] bell_q;
    logic [N-1:0] rise;
    int           start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bell_q <= '0;
        end else if (clr) begin
            bell_q <= '0;
        end else begin
            bell_q <= bell;
        end
    end

    assign rise     = bell & ~bell_q;
    assign any_rise = |rise;

`ifdef RR_ARB_EN
    logic [PW-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (int'(last) == N - 1) ? '0 : last + PW'(1);
        end
    end

    assign start = int'(ptr);
`else
    logic unused_ok;
    assign unused_ok = ^{upd, last};
    assign start     = 0;
`endif

    // Scan from the priority start, wrapping, first rise found wins.
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (!found && rise[idx]) begin
                grant = PW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/halli_galli_referee.sv
// N-player Halli Galli referee: turn order, fruit sums, bell judging, scores.
// Ports: clk, rst (async high), new_game (sync clear), card_valid/player/
// color/number flip input, bell[N] levels; outputs turn, top_valid,
// fruit_sum, ring_ok/ring_bad/ring_player, card_drop, scores, game_over,
// leader. Optional macro RR_ARB_EN enables round-robin bell arbitration.
module halli_galli_referee
    import halli_galli_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int COLOR_W      = 2,
    parameter int NUM_W        = 3,
    parameter int MAX_NUM      = 5,
    parameter int TARGET       = 5,
    parameter int SCORE_W      = 8,
    parameter int PENALTY      = 1,
    parameter int COOLDOWN_CYC = 16,
    parameter int DECK_CARDS   = 56,
    parameter int FINAL_CYC    = 64,
    localparam int PW = width_of(NUM_PLAYERS),
    localparam int SW = width_of(NUM_PLAYERS * MAX_NUM + 1),
    localparam int NF = 2 ** COLOR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_game,
    input  logic                           card_valid,
    input  logic [PW-1:0]                  card_player,
    input  logic [COLOR_W-1:0]             card_color,
    input  logic [NUM_W-1:0]               card_number,
    input  logic [NUM_PLAYERS-1:0]         bell,
    output logic [PW-1:0]                  turn,
    output logic [NUM_PLAYERS-1:0]         top_valid,
    output logic [NF*SW-1:0]               fruit_sum,
    output logic                           ring_ok,
    output logic                           ring_bad,
    output logic [PW-1:0]                  ring_player,
    output logic                           card_drop,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           game_over,
    output logic [PW-1:0]                  leader
);

    localparam int N  = NUM_PLAYERS;
    localparam int TW = width_of((COOLDOWN_CYC > FINAL_CYC) ? COOLDOWN_CYC : FINAL_CYC);
    localparam int FW = width_of(DECK_CARDS + 1);

    hg_state_t                      state;
    logic [N-1:0][COLOR_W-1:0]      top_c;
    logic [N-1:0][NUM_W-1:0]        top_n;
    logic [NF-1:0][SW-1:0]          sum_q;
    logic [NF-1:0][SW-1:0]          sum_d;
    logic [N-1:0][SCORE_W-1:0]      score_q;
    logic [TW-1:0]                  cnt;
    logic [FW-1:0]                  flips;

    logic          any_rise;
    logic [PW-1:0] grant;
    logic          match;
    logic          card_ok;
    logic          deck_out;
    logic [PW-1:0] turn_nx;
    logic [SCORE_W-1:0] score_up;
    logic [SCORE_W-1:0] score_dn;
    logic [PW-1:0] best;

    bell_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .clr      (new_game),
        .bell     (bell),
        .upd      (state == ST_JUDGE),
        .last     (ring_player),
        .any_rise (any_rise),
        .grant    (grant)
    );

    assign fruit_sum = sum_q;
    assign scores    = score_q;
    assign game_over = (state == ST_OVER);
    assign leader    = game_over ? best : '0;
    assign deck_out  = (flips == FW'(DECK_CARDS));
    assign turn_nx   = (int'(turn) == N - 1) ? '0 : turn + PW'(1);

    assign card_ok = card_valid && (card_player == turn) &&
                     (card_number != '0) &&
                     (card_number <= NUM_W'(MAX_NUM)) && !deck_out;

    // Next registered sums, built from the current face-up cards.
    always_comb begin
        sum_d = '0;
        for (int f = 0; f < NF; f++) begin
            for (int p = 0; p < N; p++) begin
                if (top_v_hit(p, f)) sum_d[f] = sum_d[f] + SW'(top_n[p]);
            end
        end
    end

    function automatic logic top_v_hit(input int p, input int f);
        return top_valid[p] && (top_c[p] == COLOR_W'(f));
    endfunction

    always_comb begin
        match = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (sum_q[f] == SW'(TARGET)) match = 1'b1;
        end
    end

    // Saturating award and penalty for the judged player.
    always_comb begin
        logic [SCORE_W:0] pop;
        logic [SCORE_W:0] tot;
        logic [SCORE_W-1:0] cur;
        cur = score_q[ring_player];
        pop = '0;
        for (int p = 0; p < N; p++) begin
            pop = pop + (SCORE_W+1)'(top_valid[p]);
        end
        tot      = {1'b0, cur} + pop;
        score_up = tot[SCORE_W] ? {SCORE_W{1'b1}} : tot[SCORE_W-1:0];
        score_dn = (cur < SCORE_W'(PENALTY)) ? '0 : cur - SCORE_W'(PENALTY);
    end

    // Highest score; strict compare keeps the lowest index on ties.
    always_comb begin
        best = '0;
        for (int p = 1; p < N; p++) begin
            if (score_q[p] > score_q[best]) best = PW'(p);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_PLAY;
            top_valid   <= '0;
            top_c       <= '0;
            top_n       <= '0;
            sum_q       <= '0;
            score_q     <= '0;
            cnt         <= '0;
            flips       <= '0;
            turn        <= '0;
            ring_ok     <= 1'b0;
            ring_bad    <= 1'b0;
            ring_player <= '0;
            card_drop   <= 1'b0;
        end else if (new_game) begin
            state       <= ST_PLAY;
            top_valid   <= '0;
            top_c       <= '0;
            top_n       <= '0;
            sum_q       <= '0;
            score_q     <= '0;
            cnt         <= '0;
            flips       <= '0;
            turn        <= '0;
            ring_ok     <= 1'b0;
            ring_bad    <= 1'b0;
            ring_player <= '0;
            card_drop   <= 1'b0;
        end else begin
            ring_ok   <= 1'b0;
            ring_bad  <= 1'b0;
            card_drop <= 1'b0;
            sum_q     <= sum_d;
            unique case (state)
                ST_PLAY, ST_FINAL: begin
                    if (any_rise) begin
                        // The bell beats a simultaneous flip.
                        ring_player <= grant;
                        state       <= ST_JUDGE;
                        card_drop   <= card_valid;
                    end else if (state == ST_PLAY && deck_out) begin
                        state     <= ST_FINAL;
                        cnt       <= '0;
                        card_drop <= card_valid;
                    end else if (state == ST_FINAL) begin
                        card_drop <= card_valid;
                        if (cnt == TW'(FINAL_CYC - 1)) state <= ST_OVER;
                        else cnt <= cnt + TW'(1);
                    end else if (card_ok) begin
                        top_valid[card_player] <= 1'b1;
                        top_c[card_player]     <= card_color;
                        top_n[card_player]     <= card_number;
                        flips <= flips + FW'(1);
                        turn  <= turn_nx;
                    end else begin
                        card_drop <= card_valid;
                    end
                end
                ST_JUDGE: begin
                    card_drop <= card_valid;
                    cnt       <= '0;
                    state     <= ST_COOL;
                    if (match) begin
                        ring_ok <= 1'b1;
                        score_q[ring_player] <= score_up;
                        top_valid <= '0;
                        turn      <= ring_player;
                    end else begin
                        ring_bad <= 1'b1;
                        score_q[ring_player] <= score_dn;
                    end
                end
                ST_COOL: begin
                    card_drop <= card_valid;
                    if (cnt == TW'(COOLDOWN_CYC - 1)) begin
                        cnt   <= '0;
                        state <= deck_out ? ST_FINAL : ST_PLAY;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ST_OVER: begin
                    card_drop <= card_valid;
                end
                default: state <= ST_PLAY;
            endcase
        end
    end

endmodule
